// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage LSU: funct3 access sizes, FSM states,
// byte-lane geometry.
package mem_stage_lsu_pkg;
    localparam int BYTE_LANES = 4;
    localparam int LANE_W     = 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store replication/strobes, load
// extraction/extension and size/alignment fault detection.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]                   funct3,
    input  logic [1:0]                   offset,
    input  logic                         mem_op,
    input  logic                         is_store,
    input  logic [BYTE_LANES*LANE_W-1:0] store_data,
    input  logic [BYTE_LANES*LANE_W-1:0] rsp_rdata,
    output logic [BYTE_LANES*LANE_W-1:0] wdata,
    output logic [BYTE_LANES-1:0]        wstrb,
    output logic [BYTE_LANES*LANE_W-1:0] load_data,
    output logic                         fault
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        bad_size;
    logic        misaligned;

    // Only real memory ops can fault; ALU ops reuse funct3 freely.
    always_comb begin
        bad_size   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        fault      = mem_op && (bad_size || misaligned);
    end

    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << offset;
            end
            default: ;
        endcase
        if (!is_store)
            wstrb = 4'b0000;
    end

    always_comb begin
        ld_byte   = rsp_rdata[{offset, 3'b000} +: 8];
        ld_half   = offset[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        load_data = rsp_rdata;
        case (funct3)
            F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  load_data = {24'b0, ld_byte};
            F3_LHU:  load_data = {16'b0, ld_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding valid/ready request to data memory,
// load extension into read_data, and a stall to the hazard unit while busy.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall_in,
    input  logic [WORD_SIZE-1:0]   alu_result,
    input  logic [WORD_SIZE-1:0]   store_data,
    input  logic [REG_SEL-1:0]     rd,
    input  logic [2:0]             funct3,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   reg_write,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [ADDR_SIZE-1:0]   mem_req_addr,
    output logic [WORD_SIZE-1:0]   mem_req_wdata,
    output logic [WORD_SIZE/8-1:0] mem_req_wstrb,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_SIZE-1:0]   mem_rsp_rdata,
    output logic [WORD_SIZE-1:0]   read_data,
    output logic [WORD_SIZE-1:0]   result,
    output logic [REG_SEL-1:0]     rd_out,
    output logic                   mem_read_out,
    output logic                   reg_write_out,
    output logic                   mem_stall,
    output logic                   mem_fault
);
    lsu_state_t             state;
    logic                   is_store;
    logic                   access;
    logic [WORD_SIZE-1:0]   al_wdata;
    logic [WORD_SIZE/8-1:0] al_wstrb;
    logic [WORD_SIZE-1:0]   al_load;
    logic                   req_we_q;
    logic [ADDR_SIZE-1:0]   req_addr_q;
    logic [WORD_SIZE-1:0]   req_wdata_q;
    logic [WORD_SIZE/8-1:0] req_wstrb_q;

    // Load wins when both read and write are flagged.
    assign is_store = mem_write & ~mem_read;
    assign access   = (mem_read | mem_write) & ~mem_fault & ~flush;

    lsu_align u_align (
        .funct3     (funct3),
        .offset     (alu_result[1:0]),
        .mem_op     (mem_read | mem_write),
        .is_store   (is_store),
        .store_data (store_data),
        .rsp_rdata  (mem_rsp_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load),
        .fault      (mem_fault)
    );

    assign result        = alu_result;
    assign rd_out        = rd;
    assign mem_read_out  = mem_read;
    assign reg_write_out = reg_write & ~mem_fault & ~flush & (state != S_DRAIN);

    // While parked in REQ the request comes from a snapshot so it cannot drift.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_stall     = 1'b0;
        mem_req_we    = is_store;
        mem_req_addr  = alu_result[ADDR_SIZE-1:0];
        mem_req_wdata = al_wdata;
        mem_req_wstrb = al_wstrb;
        case (state)
            S_IDLE: begin
                mem_req_valid = access;
                mem_stall     = access;
            end
            S_REQ: begin
                mem_req_valid = ~flush;
                mem_stall     = 1'b1;
                mem_req_we    = req_we_q;
                mem_req_addr  = req_addr_q;
                mem_req_wdata = req_wdata_q;
                mem_req_wstrb = req_wstrb_q;
            end
            S_WAIT, S_DRAIN: mem_stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            read_data   <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (access) begin
                    req_we_q    <= is_store;
                    req_addr_q  <= alu_result[ADDR_SIZE-1:0];
                    req_wdata_q <= al_wdata;
                    req_wstrb_q <= al_wstrb;
                    if (mem_req_ready)
                        state <= is_store ? S_DONE : S_WAIT;
                    else
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (flush)
                        state <= S_IDLE;
                    else if (mem_req_ready)
                        state <= req_we_q ? S_DONE : S_WAIT;
                end
                // A response coincident with flush is simply dropped.
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            read_data <= al_load;
                            state     <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (mem_rsp_valid) state <= S_IDLE;
                S_DONE:  if (!stall_in) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table of single accesses plus
// hand-written backpressure, flush/drain and reset-abandon sequences.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, stall_in;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_read, mem_write, reg_write;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [9:0]  mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata, read_data, result;
    logic [4:0]  rd_out;
    logic        mem_read_out, reg_write_out, mem_stall, mem_fault;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .alu_result(alu_result), .store_data(store_data), .rd(rd), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .read_data(read_data), .result(result), .rd_out(rd_out),
        .mem_read_out(mem_read_out), .reg_write_out(reg_write_out),
        .mem_stall(mem_stall), .mem_fault(mem_fault)
    );

    typedef struct {
        string       name;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [3:0]  exp_wstrb;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rdv, input logic [31:0] ed,
                                input logic [3:0] ws, input bit ft);
        vec_t v;
        v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd;
        v.rdata = rdv; v.exp_data = ed; v.exp_wstrb = ws; v.exp_fault = ft;
        return v;
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h exp=%h", tag, what, got, exp);
        end
    endtask

    task automatic set_nop();
        flush = 0; stall_in = 0; mem_read = 0; mem_write = 0; reg_write = 0;
        funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0; rd = 5'd0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 32'h0;
    endtask

    // Ready in the request cycle, response the cycle after (minimum latency).
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_nop();
        mem_read = !v.st; mem_write = v.st; reg_write = !v.st || v.exp_fault;
        funct3 = v.f3; alu_result = v.addr; store_data = v.sdata; rd = 5'd7;
        mem_req_ready = 1;
        #1;
        check(v.name, "fault", mem_fault, v.exp_fault);
        check(v.name, "result", result, v.addr);
        check(v.name, "rd_out", rd_out, 5'd7);
        if (v.exp_fault) begin
            check(v.name, "valid", mem_req_valid, 1'b0);
            check(v.name, "stall", mem_stall, 1'b0);
            check(v.name, "reg_write_out", reg_write_out, 1'b0);
            return;
        end
        check(v.name, "valid", mem_req_valid, 1'b1);
        check(v.name, "stall", mem_stall, 1'b1);
        check(v.name, "we", mem_req_we, v.st);
        check(v.name, "addr", mem_req_addr, v.addr[9:0]);
        check(v.name, "wstrb", mem_req_wstrb, v.exp_wstrb);
        if (v.st) begin
            check(v.name, "wdata", mem_req_wdata, v.exp_data);
            @(negedge clk);
            mem_req_ready = 0;
            #1;
            check(v.name, "done_stall", mem_stall, 1'b0);
            check(v.name, "done_valid", mem_req_valid, 1'b0);
        end else begin
            @(negedge clk);
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = v.rdata;
            #1;
            check(v.name, "wait_stall", mem_stall, 1'b1);
            check(v.name, "wait_valid", mem_req_valid, 1'b0);
            @(negedge clk);
            mem_rsp_valid = 0;
            #1;
            check(v.name, "done_stall", mem_stall, 1'b0);
            check(v.name, "read_data", read_data, v.exp_data);
            check(v.name, "reg_write_out", reg_write_out, 1'b1);
            last_load = v.exp_data;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(mk("lw_010",  0, F3_LW,  32'h010, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 0));
        vecs.push_back(mk("lb_013",  0, F3_LB,  32'h013, 0, 32'h80FF0011, 32'hFFFFFF80, 4'b0000, 0));
        vecs.push_back(mk("lbu_013", 0, F3_LBU, 32'h013, 0, 32'h80FF0011, 32'h00000080, 4'b0000, 0));
        vecs.push_back(mk("lh_012",  0, F3_LH,  32'h012, 0, 32'h80FF0011, 32'hFFFF80FF, 4'b0000, 0));
        vecs.push_back(mk("lhu_010", 0, F3_LHU, 32'h00010010, 0, 32'h1234F00D, 32'h0000F00D, 4'b0000, 0));
        vecs.push_back(mk("lb_011",  0, F3_LB,  32'h011, 0, 32'h00007F00, 32'h0000007F, 4'b0000, 0));
        vecs.push_back(mk("sh_012",  1, F3_SH,  32'h012, 32'h0000ABCD, 0, 32'hABCDABCD, 4'b1100, 0));
        vecs.push_back(mk("sb_011",  1, F3_SB,  32'h011, 32'h000000A5, 0, 32'hA5A5A5A5, 4'b0010, 0));
        vecs.push_back(mk("sw_014",  1, F3_SW,  32'h014, 32'h12345678, 0, 32'h12345678, 4'b1111, 0));
        vecs.push_back(mk("lw_011",  0, F3_LW,  32'h011, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("sh_013",  1, F3_SH,  32'h013, 32'h1, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("f3_011",  0, 3'b011, 32'h010, 0, 0, 0, 4'b0000, 1));
        vecs.push_back(mk("lh_011",  0, F3_LH,  32'h011, 0, 0, 0, 4'b0000, 1));

        set_nop();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check("reset", "read_data", read_data, 32'h0);
        check("reset", "valid", mem_req_valid, 1'b0);
        check("reset", "stall", mem_stall, 1'b0);
        rst = 0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: SW held for 4 cycles with ready low (IDLE + 3 in REQ).
        @(negedge clk);
        set_nop();
        mem_write = 1; funct3 = F3_SW; alu_result = 32'h008; store_data = 32'hCAFEF00D;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp", "valid", mem_req_valid, 1'b1);
            check("bp", "addr", mem_req_addr, 10'h008);
            check("bp", "wdata", mem_req_wdata, 32'hCAFEF00D);
            check("bp", "wstrb", mem_req_wstrb, 4'b1111);
            check("bp", "stall", mem_stall, 1'b1);
            @(negedge clk);
            #1;
        end
        mem_req_ready = 1;
        #1;
        check("bp", "accept_valid", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 0;
        #1;
        check("bp", "done_stall", mem_stall, 1'b0);
        check("bp", "done_valid", mem_req_valid, 1'b0);

        // Flush while waiting on a load; the late response must be drained.
        @(negedge clk);
        set_nop();
        mem_read = 1; reg_write = 1; funct3 = F3_LW; alu_result = 32'h020; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; flush = 1;
        #1;
        check("flush", "wait_stall", mem_stall, 1'b1);
        check("flush", "wait_rwo", reg_write_out, 1'b0);
        @(negedge clk);
        set_nop(); reg_write = 1;
        #1;
        check("flush", "drain_stall", mem_stall, 1'b1);
        check("flush", "drain_rwo", reg_write_out, 1'b0);
        check("flush", "drain_valid", mem_req_valid, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h11111111;
        #1;
        check("flush", "rsp_stall", mem_stall, 1'b1);
        @(negedge clk);
        mem_rsp_valid = 0;
        #1;
        check("flush", "idle_stall", mem_stall, 1'b0);
        check("flush", "idle_rwo", reg_write_out, 1'b1);
        check("flush", "read_data_kept", read_data, last_load);

        // Reset while waiting; a late response must be ignored in IDLE.
        @(negedge clk);
        set_nop();
        mem_read = 1; reg_write = 1; funct3 = F3_LW; alu_result = 32'h030; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        set_nop();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hBADBAD00;
        #1;
        check("rst_wait", "read_data", read_data, 32'h0);
        check("rst_wait", "stall", mem_stall, 1'b0);
        check("rst_wait", "valid", mem_req_valid, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 0;
        #1;
        check("rst_wait", "read_data_late", read_data, 32'h0);
        check("rst_wait", "stall_late", mem_stall, 1'b0);

        run_vec(vecs[0]);

        @(negedge clk);
        set_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
